lsu: RTL and testbench

Load/store unit: the bus initiator that issues requests to the data-memory responder (`ram`) on the req/gnt handshake. It sits between the core's execute stage and the data bus. It checks alignment, drives address, write data, write enable and size, and holds the request until grant or timeout. On loads it sign- or zero-extends the lane-aligned read data and returns a one-cycle completion pulse to the core.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_extend.sv | 50 +++++
 rtl/lsu.sv | 147 ++++++++++++++
 tb/tb_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Bus sizes, RV32I load/store funct3 values and FSM states.
package lsu_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_WAIT = 3'b010;
  localparam logic [2:0] S_RESP = 3'b100;

  localparam int SI_IDLE = 0;
  localparam int SI_WAIT = 1;
  localparam int SI_RESP = 2;

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: funct3 legality, alignment check and
// sign/zero extension of lane-aligned load data.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic        bad_o,
  output logic [31:0] ext_o
);

  logic legal;
  logic misal;

  // Decode size, reject illegal/misaligned, extend read data
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    ext_o = rdata_i;
    case (f3_i)
      F3_B: begin
        legal = 1'b1;
        ext_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      end
      F3_H: begin
        legal = 1'b1;
        misal = addr_lo_i[0];
        ext_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      end
      F3_W: begin
        legal = 1'b1;
        misal = |addr_lo_i;
      end
      F3_BU: begin
        legal = !we_i;
      end
      F3_HU: begin
        legal = !we_i;
        misal = addr_lo_i[0];
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    bad_o = !legal || misal;
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store bus initiator with req/gnt handshake,
// grant timeout and one-cycle completion pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_fault_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        we_o,
  output logic [1:0]  hb_o,
  input  logic [31:0] rdata_i
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic          flt_q, flt_d;

  logic          idle;
  logic [2:0]    f3_sel;
  logic          we_sel;
  logic          bad;
  logic [31:0]   ext;

  assign idle   = state_q[SI_IDLE];
  assign f3_sel = idle ? lsu_funct3_i : f3_q;
  assign we_sel = idle ? lsu_we_i : we_q;

  lsu_extend u_ext (
    .f3_i      (f3_sel),
    .we_i      (we_sel),
    .addr_lo_i (lsu_addr_i[1:0]),
    .rdata_i   (rdata_i),
    .bad_o     (bad),
    .ext_o     (ext)
  );

  assign lsu_busy_o     = !idle;
  assign lsu_done_o     = state_q[SI_RESP];
  assign lsu_misalign_o = state_q[SI_RESP] & mis_q;
  assign lsu_fault_o    = state_q[SI_RESP] & flt_q;
  assign lsu_rdata_o    = rdata_q;
  assign req_o          = state_q[SI_WAIT];
  assign addr_o         = addr_q;
  assign wdata_o        = wdata_q;
  assign we_o           = we_q;
  assign hb_o           = f3_q[1:0];

  // Next-state: accept, wait for grant or timeout, respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    unique case (1'b1)
      state_q[SI_IDLE]: begin
        mis_d = 1'b0;
        flt_d = 1'b0;
        if (lsu_req_i) begin
          if (bad) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            addr_d  = lsu_addr_i;
            wdata_d = lsu_wdata_i;
            we_d    = lsu_we_i;
            f3_d    = lsu_funct3_i;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      state_q[SI_WAIT]: begin
        if (gnt_i) begin
          if (!we_q) rdata_d = ext;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          flt_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      state_q[SI_RESP]: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bus registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu with a small
// grant-after-two-cycles memory responder.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_misalign_o;
  logic        lsu_fault_o;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        we_o;
  logic [1:0]  hb_o;
  logic [31:0] rdata_i;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_funct3_i   (lsu_funct3_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_busy_o     (lsu_busy_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_fault_o    (lsu_fault_o),
    .req_o          (req_o),
    .gnt_i          (gnt_i),
    .addr_o         (addr_o),
    .wdata_o        (wdata_o),
    .we_o           (we_o),
    .hb_o           (hb_o),
    .rdata_i        (rdata_i)
  );

  // responder: grant in the third req-high cycle
  logic [7:0] mem [0:255];
  logic [1:0] rcnt;
  logic       gnt_en;
  logic [7:0] wa;
  logic [31:0] word;
  logic [31:0] sh;

  assign gnt_i = gnt_en && req_o && (rcnt == 2'd2);

  always @(posedge clk) begin
    if (rst_i || !req_o || gnt_i) rcnt <= 2'd0;
    else if (rcnt != 2'd3) rcnt <= rcnt + 2'd1;
  end

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hF0;
      mem[17] <= 8'hF0;
      mem[18] <= 8'h00;
      mem[19] <= 8'h80;
    end else if (req_o && gnt_i && we_o) begin
      case (hb_o)
        2'b00: mem[addr_o[7:0]] <= wdata_o[7:0];
        2'b01: begin
          mem[{addr_o[7:1], 1'b0}] <= wdata_o[7:0];
          mem[{addr_o[7:1], 1'b1}] <= wdata_o[15:8];
        end
        default: begin
          mem[{addr_o[7:2], 2'd0}] <= wdata_o[7:0];
          mem[{addr_o[7:2], 2'd1}] <= wdata_o[15:8];
          mem[{addr_o[7:2], 2'd2}] <= wdata_o[23:16];
          mem[{addr_o[7:2], 2'd3}] <= wdata_o[31:24];
        end
      endcase
    end
  end

  always_comb begin
    wa   = {addr_o[7:2], 2'b00};
    word = {mem[wa + 8'd3], mem[wa + 8'd2],
            mem[wa + 8'd1], mem[wa]};
    sh   = word >> {addr_o[1:0], 3'b000};
    case (hb_o)
      2'b00:   rdata_i = {24'h0, sh[7:0]};
      2'b01:   rdata_i = {16'h0, sh[15:0]};
      default: rdata_i = sh;
    endcase
  end

  // scoreboard
  typedef struct {
    int          cyc;
    int          reqs;
    logic [1:0]  hb;
    logic [31:0] rd;
    logic        mis;
    logic        flt;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nerr = 0;
  int   nexp = 0;
  int   ndone = 0;
  int   cyc = 0;
  int   reqs = 0;
  logic [1:0] hb_seen = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s op%0d: got %h expected %h",
               nm, tag, act, exp);
    end
  endtask

  // monitor: pop and compare on each completion
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      reqs = 0;
    end else begin
      if (req_o) begin
        reqs++;
        hb_seen = hb_o;
      end
      if (lsu_done_o) begin
        ndone++;
        if (sbq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", e.tag, cyc, e.cyc);
          chk("req_cycles", e.tag, reqs, e.reqs);
          chk("misalign", e.tag, {31'b0, lsu_misalign_o},
              {31'b0, e.mis});
          chk("fault", e.tag, {31'b0, lsu_fault_o},
              {31'b0, e.flt});
          chk("rdata", e.tag, lsu_rdata_o, e.rd);
          chk("req_at_done", e.tag, {31'b0, req_o}, 32'd0);
          if (e.reqs > 0)
            chk("hb", e.tag, {30'b0, hb_seen}, {30'b0, e.hb});
        end
        reqs = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input int lat, input int nreq,
                       input logic [31:0] rd,
                       input logic mis, input logic flt,
                       input int tag);
    exp_t e;
    int n;
    @(negedge clk);
    lsu_req_i    = 1'b1;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wd;
    e.cyc  = cyc + lat;
    e.reqs = nreq;
    e.hb   = f3[1:0];
    e.rd   = rd;
    e.mis  = mis;
    e.flt  = flt;
    e.tag  = tag;
    sbq.push_back(e);
    nexp++;
    @(negedge clk);
    lsu_req_i = 1'b0;
    n = 0;
    while (ndone < nexp && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (ndone < nexp) begin
      nchk++;
      nerr++;
      $display("FAIL no_done op%0d: got 0 expected 1", tag);
      sbq.delete();
      ndone = nexp;
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'b000;
    lsu_addr_i   = 32'h0;
    lsu_wdata_i  = 32'h0;
    gnt_en       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 0, {31'b0, req_o}, 32'd0);
    chk("rst_we", 0, {31'b0, we_o}, 32'd0);
    chk("rst_addr", 0, addr_o, 32'd0);
    chk("rst_wdata", 0, wdata_o, 32'd0);
    chk("rst_hb", 0, {30'b0, hb_o}, 32'd0);
    chk("rst_busy", 0, {31'b0, lsu_busy_o}, 32'd0);
    chk("rst_done", 0, {31'b0, lsu_done_o}, 32'd0);
    chk("rst_rdata", 0, lsu_rdata_o, 32'd0);
    chk("rst_mis", 0, {31'b0, lsu_misalign_o}, 32'd0);
    chk("rst_flt", 0, {31'b0, lsu_fault_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    issue(0, F3_W,  32'h10, 32'h0,   4, 3, 32'h8000F0F0, 0, 0, 1);
    issue(1, F3_B,  32'h13, 32'hAB,  4, 3, 32'h8000F0F0, 0, 0, 2);
    issue(0, F3_B,  32'h13, 32'h0,   4, 3, 32'hFFFFFFAB, 0, 0, 3);
    issue(0, F3_BU, 32'h13, 32'h0,   4, 3, 32'h000000AB, 0, 0, 4);
    issue(1, F3_H,  32'h22, 32'h8001, 4, 3, 32'h000000AB, 0, 0, 5);
    issue(0, F3_H,  32'h22, 32'h0,   4, 3, 32'hFFFF8001, 0, 0, 6);
    issue(0, F3_HU, 32'h22, 32'h0,   4, 3, 32'h00008001, 0, 0, 7);
    issue(0, F3_W,  32'h11, 32'h0,   1, 0, 32'h00008001, 1, 0, 8);
    issue(0, 3'b011, 32'h10, 32'h0,  1, 0, 32'h00008001, 1, 0, 9);
    issue(1, 3'b100, 32'h10, 32'h0,  1, 0, 32'h00008001, 1, 0, 10);
    issue(1, F3_H,  32'h23, 32'h0,   1, 0, 32'h00008001, 1, 0, 11);
    issue(1, F3_W,  32'h30, 32'h12345678, 4, 3,
          32'h00008001, 0, 0, 12);
    issue(0, F3_W,  32'h30, 32'h0,   4, 3, 32'h12345678, 0, 0, 13);
    issue(0, F3_B,  32'h31, 32'h0,   4, 3, 32'h00000056, 0, 0, 14);
    issue(0, F3_H,  32'h32, 32'h0,   4, 3, 32'h00001234, 0, 0, 15);
    issue(0, F3_B,  32'h10, 32'h0,   4, 3, 32'hFFFFFFF0, 0, 0, 16);

    gnt_en = 1'b0;
    issue(0, F3_W,  32'h10, 32'h0,   5, 4, 32'hFFFFFFF0, 0, 1, 17);
    gnt_en = 1'b1;

    // reset abandons a transaction in flight
    @(negedge clk);
    lsu_req_i    = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = F3_W;
    lsu_addr_i   = 32'h10;
    @(negedge clk);
    lsu_req_i = 1'b0;
    chk("req_before_rst", 18, {31'b0, req_o}, 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("req_after_rst", 18, {31'b0, req_o}, 32'd0);
    chk("busy_after_rst", 18, {31'b0, lsu_busy_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (8) @(posedge clk);
    chk("no_done_after_rst", 18, ndone, nexp);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
